// File: rtl/vga_stream_driver.sv
// Parametrised VGA timing generator with a stream-fed pixel FIFO and built-in test patterns; all outputs except pix_ready are registered, 1 cycle after (hc,vc).
// Backpressure: pix_ready drops when the FIFO is full or resync is high; pixels are popped only at active positions in stream mode.
module vga_stream_driver #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit HS_POL     = 1'b0,
  parameter bit VS_POL     = 1'b0,
  parameter int COLOR_BITS = 2,
  parameter int FIFO_DEPTH = 16,
  parameter int CW         = 10
) (
  input  logic                    clk_pix,
  input  logic                    rst_pix,
  input  logic [3*COLOR_BITS-1:0] pix_data,
  input  logic                    pix_valid,
  output logic                    pix_ready,
  input  logic [1:0]              mode,
  input  logic                    resync,
  input  logic                    underflow_clr,
  output logic [COLOR_BITS-1:0]   vga_r,
  output logic [COLOR_BITS-1:0]   vga_g,
  output logic [COLOR_BITS-1:0]   vga_b,
  output logic                    hsync,
  output logic                    vsync,
  output logic                    de,
  output logic [CW-1:0]           sx,
  output logic [CW-1:0]           sy,
  output logic                    frame_start,
  output logic                    underflow
);

  typedef struct packed {
    logic [COLOR_BITS-1:0] r;
    logic [COLOR_BITS-1:0] g;
    logic [COLOR_BITS-1:0] b;
  } rgb_t;

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int BAR_W   = H_ACTIVE / 8;
  localparam int PW      = 3 * COLOR_BITS;
  localparam int AW      = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);

  logic [CW-1:0] hc, vc;
  logic          act, hs_on, vs_on;
  logic [2:0]    bar;
  rgb_t          pix_nxt, fifo_dat;

  logic [PW-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          fifo_vld, fifo_full, push, pop, underflow_set;

  always_ff @(posedge clk_pix) begin
    if (rst_pix || resync) begin
      hc <= '0;
      vc <= '0;
    end else if (hc == H_LAST) begin
      hc <= '0;
      vc <= (vc == V_LAST) ? '0 : vc + 1'b1;
    end else begin
      hc <= hc + 1'b1;
    end
  end

  assign act   = (hc < H_ACT) && (vc < V_ACT);
  assign hs_on = (hc >= HS_BEG) && (hc < HS_END);
  assign vs_on = (vc >= VS_BEG) && (vc < VS_END);

  // Full when pointers alias with opposite wrap bits; resync blocks pushes so the flush cycle drops them.
  assign fifo_vld  = (wr_ptr != rd_ptr);
  assign fifo_full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pix_ready = !fifo_full && !resync;
  assign push      = pix_valid && pix_ready;
  assign pop       = (mode == 2'b00) && act && fifo_vld;
  assign fifo_dat  = fifo_mem[rd_ptr[AW-1:0]];

  assign underflow_set = (mode == 2'b00) && act && !fifo_vld;

  always_ff @(posedge clk_pix) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= pix_data;
  end

  always_ff @(posedge clk_pix) begin
    if (rst_pix || resync) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Bar index by threshold count avoids a divider when H_ACTIVE/8 is not a power of two.
  always_comb begin
    bar = '0;
    for (int k = 1; k < 8; k++) begin
      if (hc >= CW'(k * BAR_W)) bar = bar + 3'd1;
    end
  end

  always_comb begin
    pix_nxt = '0;
    if (act) begin
      case (mode)
        2'b00: if (fifo_vld) pix_nxt = fifo_dat;
        2'b01: begin
          pix_nxt.r = {COLOR_BITS{bar[2]}};
          pix_nxt.g = {COLOR_BITS{bar[1]}};
          pix_nxt.b = {COLOR_BITS{bar[0]}};
        end
        2'b10: if (hc[3:0] == 4'd0 || vc[3:0] == 4'd0) pix_nxt = '1;
        default: pix_nxt = '0;
      endcase
    end
  end

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      sx          <= '0;
      sy          <= '0;
      de          <= 1'b0;
      frame_start <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      underflow   <= 1'b0;
    end else begin
      sx          <= hc;
      sy          <= vc;
      de          <= act;
      frame_start <= (hc == '0) && (vc == '0);
      hsync       <= hs_on ? HS_POL : ~HS_POL;
      vsync       <= vs_on ? VS_POL : ~VS_POL;
      vga_r       <= pix_nxt.r;
      vga_g       <= pix_nxt.g;
      vga_b       <= pix_nxt.b;
      if (underflow_set)      underflow <= 1'b1;
      else if (underflow_clr) underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_stream_driver.sv
// Directed bench for vga_stream_driver on a reduced 48x28 raster (32x20 active), HS_POL=0, VS_POL=1, 8-entry FIFO.
module tb_vga_stream_driver;

  localparam int HA = 32, HF = 4, HS = 6, HB = 6, HT = HA + HF + HS + HB;
  localparam int VA = 20, VF = 2, VSW = 3, VB = 3, VT = VA + VF + VSW + VB;
  localparam int FRAME = HT * VT;

  logic       clk_pix = 1'b0;
  logic       rst_pix, pix_valid, pix_ready, resync, underflow_clr;
  logic [5:0] pix_data;
  logic [1:0] mode;
  logic [1:0] vga_r, vga_g, vga_b;
  logic       hsync, vsync, de, frame_start, underflow;
  logic [7:0] sx, sy;
  logic [5:0] rgb;

  int checks = 0;
  int errors = 0;
  int p = 0;
  int plimit = 0;

  assign rgb = {vga_r, vga_g, vga_b};

  always #5 clk_pix = ~clk_pix;

  vga_stream_driver #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b1), .COLOR_BITS(2), .FIFO_DEPTH(8), .CW(8)
  ) dut (
    .clk_pix(clk_pix), .rst_pix(rst_pix),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .mode(mode), .resync(resync), .underflow_clr(underflow_clr),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .hsync(hsync), .vsync(vsync), .de(de),
    .sx(sx), .sy(sy), .frame_start(frame_start), .underflow(underflow)
  );

  task automatic tick;
    @(posedge clk_pix);
    #1;
  endtask

  // Producer offers value p%HA while p < plimit; p advances only on an accepted push.
  task automatic stream_tick;
    logic rdy;
    pix_valid = (p < plimit);
    pix_data  = 6'(p % HA);
    #1;
    rdy = pix_ready;
    @(posedge clk_pix);
    #1;
    if (pix_valid && rdy) p++;
  endtask

  task automatic do_reset(input logic [1:0] m);
    rst_pix = 1'b1; mode = m; pix_valid = 1'b0; resync = 1'b0; underflow_clr = 1'b0;
    tick(); tick();
    rst_pix = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    rst_pix = 1'b1; mode = 2'b11; pix_valid = 1'b0; pix_data = '0; resync = 1'b0; underflow_clr = 1'b0;
    repeat (3) tick();
    checks++; if (hsync !== 1'b1) begin errors++; $display("FAIL reset_hsync: got %b expected 1", hsync); end
    checks++; if (vsync !== 1'b0) begin errors++; $display("FAIL reset_vsync: got %b expected 0", vsync); end
    checks++; if (de !== 1'b0) begin errors++; $display("FAIL reset_de: got %b expected 0", de); end
    checks++; if (rgb !== 6'd0) begin errors++; $display("FAIL reset_rgb: got %h expected 0", rgb); end
    checks++; if (sx !== 8'd0 || sy !== 8'd0) begin errors++; $display("FAIL reset_pos: got %0d,%0d expected 0,0", sx, sy); end
    checks++; if (frame_start !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL reset_flags: got fs=%b uf=%b expected 0,0", frame_start, underflow); end
    rst_pix = 1'b0;
    tick();
    checks++; if (sx !== 8'd0 || sy !== 8'd0 || de !== 1'b1 || frame_start !== 1'b1) begin
      errors++; $display("FAIL first_pixel: got sx=%0d sy=%0d de=%b fs=%b expected 0,0,1,1", sx, sy, de, frame_start); end
    tick();
    checks++; if (sx !== 8'd1 || frame_start !== 1'b0) begin errors++; $display("FAIL second_pixel: got sx=%0d fs=%b expected 1,0", sx, frame_start); end
  endtask

  task automatic test_timing;
    int de_cnt = 0, hs_cnt = 0, vs_cnt = 0, fs_cnt = 0, pos_err = 0, dec_err = 0, lit = 0;
    int fs_t0 = -1, fs_per = -1, ex, ey;
    logic ehs, evs, ede;
    do_reset(2'b11);
    for (int t = 0; t < 2 * FRAME; t++) begin
      ex = t % HT;
      ey = (t / HT) % VT;
      ehs = !(ex >= HA + HF && ex < HA + HF + HS);
      evs = (ey >= VA + VF && ey < VA + VF + VSW);
      ede = (ex < HA) && (ey < VA);
      if (sx !== 8'(ex) || sy !== 8'(ey)) pos_err++;
      if (hsync !== ehs || vsync !== evs || de !== ede) dec_err++;
      if (de === 1'b1) de_cnt++;
      if (hsync === 1'b0) hs_cnt++;
      if (vsync === 1'b1) vs_cnt++;
      if (rgb !== 6'd0) lit++;
      if (frame_start === 1'b1) begin
        fs_cnt++;
        if (fs_t0 < 0) fs_t0 = t;
        else if (fs_per < 0) fs_per = t - fs_t0;
      end
      tick();
    end
    checks++; if (pos_err != 0) begin errors++; $display("FAIL timing_pos: got %0d bad cycles expected 0", pos_err); end
    checks++; if (dec_err != 0) begin errors++; $display("FAIL timing_decode: got %0d bad cycles expected 0", dec_err); end
    checks++; if (de_cnt != 2 * HA * VA) begin errors++; $display("FAIL timing_de_count: got %0d expected %0d", de_cnt, 2 * HA * VA); end
    checks++; if (hs_cnt != 2 * VT * HS) begin errors++; $display("FAIL timing_hsync_count: got %0d expected %0d", hs_cnt, 2 * VT * HS); end
    checks++; if (vs_cnt != 2 * VSW * HT) begin errors++; $display("FAIL timing_vsync_count: got %0d expected %0d", vs_cnt, 2 * VSW * HT); end
    checks++; if (fs_cnt != 2 || fs_per != FRAME) begin errors++; $display("FAIL timing_frame_start: got count=%0d period=%0d expected 2,%0d", fs_cnt, fs_per, FRAME); end
    checks++; if (lit != 0) begin errors++; $display("FAIL black_mode_rgb: got %0d lit pixels expected 0", lit); end
  endtask

  task automatic test_stream;
    int err = 0, act = 0, rdy_hi = 0, rdy_lo = 0, guard = 0;
    do_reset(2'b11);
    p = 0; plimit = 1 << 30;
    while (sy < 8'(VA) && guard < 2 * FRAME) begin stream_tick(); guard++; end
    mode = 2'b00;
    guard = 0;
    while (frame_start !== 1'b1 && guard < 2 * FRAME) begin stream_tick(); guard++; end
    checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL stream_sync: got fs=%b expected 1 within bound", frame_start); end
    for (int t = 0; t < FRAME; t++) begin
      if (de === 1'b1) begin
        act++;
        if (rgb !== sx[5:0]) err++;
      end
      if (pix_ready === 1'b1) rdy_hi++; else rdy_lo++;
      stream_tick();
    end
    checks++; if (err != 0) begin errors++; $display("FAIL stream_data: got %0d wrong pixels expected 0", err); end
    checks++; if (act != HA * VA) begin errors++; $display("FAIL stream_active: got %0d expected %0d", act, HA * VA); end
    checks++; if (!(rdy_hi > 0 && rdy_lo > 0)) begin errors++; $display("FAIL stream_ready_toggle: got hi=%0d lo=%0d expected both nonzero", rdy_hi, rdy_lo); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL stream_underflow: got %b expected 0", underflow); end
    pix_valid = 1'b0;
  endtask

  task automatic test_underflow;
    int err = 0, guard = 0;
    logic uf19, uf20;
    do_reset(2'b11);
    p = 0; plimit = 20;
    while (sy < 8'(VA) && guard < 2 * FRAME) begin stream_tick(); guard++; end
    mode = 2'b00;
    guard = 0;
    while (frame_start !== 1'b1 && guard < 2 * FRAME) begin stream_tick(); guard++; end
    checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL underflow_sync: got fs=%b expected 1 within bound", frame_start); end
    uf19 = 1'bx; uf20 = 1'bx;
    for (int t = 0; t < 22; t++) begin
      if (sx !== 8'(t)) err++;
      if (t < 20) begin
        if (rgb !== 6'(t)) err++;
      end else if (rgb !== 6'd0) err++;
      if (t == 19) uf19 = underflow;
      if (t == 20) uf20 = underflow;
      stream_tick();
    end
    checks++; if (err != 0) begin errors++; $display("FAIL underflow_pixels: got %0d wrong pixels expected 0", err); end
    checks++; if (uf19 !== 1'b0) begin errors++; $display("FAIL underflow_before: got %b expected 0", uf19); end
    checks++; if (uf20 !== 1'b1) begin errors++; $display("FAIL underflow_set: got %b expected 1", uf20); end
    underflow_clr = 1'b1;
    stream_tick();
    underflow_clr = 1'b0;
    checks++; if (underflow !== 1'b1 || rgb !== 6'd0) begin errors++; $display("FAIL underflow_set_wins: got uf=%b rgb=%h expected 1,0", underflow, rgb); end
    mode = 2'b11; underflow_clr = 1'b1;
    tick();
    underflow_clr = 1'b0;
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL underflow_clear: got %b expected 0", underflow); end
    guard = 0;
    while (sx !== 8'(HA) && guard < HT) begin tick(); guard++; end
    mode = 2'b00;
    repeat (10) tick();
    checks++; if (underflow !== 1'b0 || de !== 1'b0) begin errors++; $display("FAIL underflow_blanking: got uf=%b de=%b expected 0,0", underflow, de); end
    mode = 2'b11;
  endtask

  task automatic test_mid_reset;
    do_reset(2'b00);
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL midreset_pre: got uf=%b expected 1", underflow); end
    mode = 2'b11; pix_valid = 1'b1; pix_data = 6'h15;
    repeat (3) tick();
    pix_valid = 1'b0;
    tick();
    rst_pix = 1'b1; mode = 2'b00;
    tick();
    checks++; if (underflow !== 1'b0 || de !== 1'b0 || sx !== 8'd0 || rgb !== 6'd0 || hsync !== 1'b1) begin
      errors++; $display("FAIL midreset_state: got uf=%b de=%b sx=%0d rgb=%h hs=%b expected 0,0,0,0,1", underflow, de, sx, rgb, hsync); end
    rst_pix = 1'b0;
    tick();
    checks++; if (de !== 1'b1 || rgb !== 6'd0 || underflow !== 1'b1) begin
      errors++; $display("FAIL midreset_fifo_discard: got de=%b rgb=%h uf=%b expected 1,0,1", de, rgb, underflow); end
  endtask

  task automatic test_colour_bars;
    logic [5:0] line [HT];
    logic [5:0] e;
    logic [2:0] bi;
    int err = 0;
    do_reset(2'b01);
    for (int t = 0; t < HT; t++) begin
      line[t] = rgb;
      bi = 3'(t / (HA / 8));
      e = (t < HA) ? {{2{bi[2]}}, {2{bi[1]}}, {2{bi[0]}}} : 6'd0;
      if (rgb !== e || sx !== 8'(t)) err++;
      tick();
    end
    checks++; if (err != 0) begin errors++; $display("FAIL bars_line: got %0d wrong pixels expected 0", err); end
    checks++; if (line[0] !== 6'b000000) begin errors++; $display("FAIL bars_sx0: got %b expected 000000", line[0]); end
    checks++; if (line[4] !== 6'b000011) begin errors++; $display("FAIL bars_sx4: got %b expected 000011", line[4]); end
    checks++; if (line[12] !== 6'b001111) begin errors++; $display("FAIL bars_sx12: got %b expected 001111", line[12]); end
    checks++; if (line[16] !== 6'b110000) begin errors++; $display("FAIL bars_sx16: got %b expected 110000", line[16]); end
    checks++; if (line[31] !== 6'b111111) begin errors++; $display("FAIL bars_sx31: got %b expected 111111", line[31]); end
    checks++; if (line[40] !== 6'b000000) begin errors++; $display("FAIL bars_blank: got %b expected 000000", line[40]); end
  endtask

  task automatic test_grid;
    logic [5:0] g0 [HT];
    logic [5:0] g1 [HT];
    int white = 0;
    do_reset(2'b10);
    for (int t = 0; t < 2 * HT; t++) begin
      if (t < HT) g0[t] = rgb;
      else g1[t - HT] = rgb;
      tick();
    end
    for (int i = 0; i < HT; i++) if (g1[i] === 6'h3f) white++;
    checks++; if (g0[7] !== 6'h3f) begin errors++; $display("FAIL grid_row0: got %h expected 3f", g0[7]); end
    checks++; if (g0[40] !== 6'h00) begin errors++; $display("FAIL grid_blank: got %h expected 00", g0[40]); end
    checks++; if (g1[0] !== 6'h3f || g1[16] !== 6'h3f) begin errors++; $display("FAIL grid_col: got %h,%h expected 3f,3f", g1[0], g1[16]); end
    checks++; if (g1[5] !== 6'h00) begin errors++; $display("FAIL grid_off: got %h expected 00", g1[5]); end
    checks++; if (white != 2) begin errors++; $display("FAIL grid_count: got %0d expected 2", white); end
  endtask

  task automatic test_resync;
    int guard = 0;
    do_reset(2'b11);
    pix_valid = 1'b1; pix_data = 6'h21;
    repeat (5) tick();
    pix_valid = 1'b0;
    while (!(sx === 8'd20 && sy === 8'd10) && guard < FRAME) begin tick(); guard++; end
    checks++; if (sx !== 8'd20 || sy !== 8'd10) begin errors++; $display("FAIL resync_reach: got %0d,%0d expected 20,10", sx, sy); end
    resync = 1'b1; pix_valid = 1'b1; pix_data = 6'h2a;
    #1;
    checks++; if (pix_ready !== 1'b0) begin errors++; $display("FAIL resync_ready: got %b expected 0", pix_ready); end
    tick();
    resync = 1'b0; pix_valid = 1'b0; mode = 2'b00;
    tick();
    checks++; if (sx !== 8'd0 || sy !== 8'd0 || frame_start !== 1'b1) begin
      errors++; $display("FAIL resync_origin: got sx=%0d sy=%0d fs=%b expected 0,0,1", sx, sy, frame_start); end
    checks++; if (rgb !== 6'd0 || underflow !== 1'b1) begin
      errors++; $display("FAIL resync_flush: got rgb=%h uf=%b expected 0,1", rgb, underflow); end
    tick();
    checks++; if (sx !== 8'd1 || frame_start !== 1'b0) begin errors++; $display("FAIL resync_advance: got sx=%0d fs=%b expected 1,0", sx, frame_start); end
  endtask

  task automatic test_resync_hold;
    mode = 2'b11;
    repeat (30) tick();
    resync = 1'b1;
    tick();
    tick();
    checks++; if (sx !== 8'd0 || sy !== 8'd0 || frame_start !== 1'b1) begin
      errors++; $display("FAIL hold_a: got sx=%0d sy=%0d fs=%b expected 0,0,1", sx, sy, frame_start); end
    tick();
    checks++; if (sx !== 8'd0 || sy !== 8'd0 || frame_start !== 1'b1) begin
      errors++; $display("FAIL hold_b: got sx=%0d sy=%0d fs=%b expected 0,0,1", sx, sy, frame_start); end
    resync = 1'b0;
    tick();
    checks++; if (sx !== 8'd0 || frame_start !== 1'b1) begin errors++; $display("FAIL hold_release: got sx=%0d fs=%b expected 0,1", sx, frame_start); end
    tick();
    checks++; if (sx !== 8'd1 || frame_start !== 1'b0) begin errors++; $display("FAIL hold_run: got sx=%0d fs=%b expected 1,0", sx, frame_start); end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_stream();
    test_underflow();
    test_mid_reset();
    test_colour_bars();
    test_grid();
    test_resync();
    test_resync_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_stream_driver.md
Name: vga_stream_driver

Overview:
- Parametrised VGA timing generator and pixel output stage, successor to the fixed 640x480 driver.
- Generates configurable sync and blanking timing with programmable sync polarity and colour depth.
- Sources active pixels from a valid/ready stream through an internal FIFO, or from built-in test patterns.
- Sits between the pixel source (framebuffer reader or Wishbone pixel writer) and the VGA pins.

Parameters:
H_ACTIVE, 640, active pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, active lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, hsync active level (0 = negative polarity)
VS_POL, 0, vsync active level
COLOR_BITS, 2, bits per colour channel
FIFO_DEPTH, 16, pixel FIFO entries; must be a power of 2, >=2
CW, 10, width of sx/sy; must hold H_total-1 and V_total-1

Ports:
clk_pix  input  1  pixel clock
rst_pix  input  1  reset, synchronous, active-high
pix_data  input  3*COLOR_BITS  pixel {r,g,b}, r in MSBs
pix_valid  input  1  pixel stream valid
pix_ready  output  1  FIFO can accept a pixel (= !full && !resync)
mode  input  2  00 stream, 01 colour bars, 10 grid, 11 black
resync  input  1  restart frame at (0,0) and flush FIFO
underflow_clr  input  1  clear underflow flag
vga_r  output  COLOR_BITS  red
vga_g  output  COLOR_BITS  green
vga_b  output  COLOR_BITS  blue
hsync  output  1  horizontal sync
vsync  output  1  vertical sync
de  output  1  data enable (high in active area)
sx  output  CW  horizontal position of the pixel currently on the outputs
sy  output  CW  vertical position of the pixel currently on the outputs
frame_start  output  1  high for one cycle when sx==0 && sy==0
underflow  output  1  sticky: stream mode needed a pixel but the FIFO was empty

Behaviour:
- Clock and reset: one clock, clk_pix; rst_pix is synchronous and active-high.
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Internal counters hc and vc:
  - hc increments each cycle; it wraps at H_TOTAL-1 to 0 and advances vc.
  - vc wraps at V_TOTAL-1 to 0.
- Output alignment: all outputs except pix_ready are registered from (hc,vc) with 1-cycle latency. sx, sy, de, syncs, rgb and frame_start are therefore mutually aligned.
- Active-area and sync decode:
  - de = hc<H_ACTIVE && vc<V_ACTIVE.
  - hsync = HS_POL when H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC, else ~HS_POL. vsync uses the same form with the V parameters.
- Reset state:
  - hc=vc=0, FIFO empty, underflow=0.
  - Outputs: sx=sy=0, rgb=0, de=0, frame_start=0, hsync=~HS_POL, vsync=~VS_POL.
  - First cycle after reset release presents pixel (0,0).
- RGB is forced to 0 whenever de is 0, in every mode.
- FIFO:
  - Push on pix_valid && pix_ready.
  - Pop only when mode==00 and the current position is active and the FIFO is non-empty.
  - Push and pop in the same cycle are both allowed; on a full FIFO, pop-then-push semantics do NOT apply (pix_ready already low).
- Stream mode (00):
  - Active pixel = popped FIFO word.
  - If the FIFO is empty at an active position: output black and set underflow.
  - No pop in blanking.
- Colour-bar mode (01):
  - 8 vertical bars of width H_ACTIVE/8; H_ACTIVE must be divisible by 8.
  - Bar index i = 0..7 from the left.
  - r = all bits i[2], g = all bits i[1], b = all bits i[0]. Bar 0 is black, bar 7 is white.
- Grid mode (10): white where hc[3:0]==0 or vc[3:0]==0, otherwise black.
- Black mode (11): all active pixels black.
- Mode changes are sampled every cycle and apply to the next output pixel.
- Modes other than 00 never pop; the FIFO keeps filling until full.
- resync:
  - Next cycle hc=vc=0 and the FIFO is emptied.
  - Any push in the resync cycle is dropped (pix_ready=0 while resync=1).
  - Outputs follow from (0,0) one cycle later.
  - Asserted mid-line or mid-frame, it still truncates the frame immediately.
  - Held high, outputs stay at (0,0) with frame_start high each cycle.
- underflow: set by an empty-FIFO active pixel, cleared by underflow_clr; set wins if both occur in the same cycle.
- Reset mid-operation behaves exactly as the reset state above: the FIFO is discarded and the flag is cleared.

Test Plan:
- Reset for 3 cycles, release -> during reset hsync=vsync=1, de=0, rgb=0; first cycle after release sx=0, sy=0, de=1, frame_start=1.
- Default params, mode=11, run 2 frames -> frame_start period exactly 420000 cycles; hsync low for 96 cycles at sx=656..751; vsync low on sy=490..491; de high 640x480 per frame.
- Stream mode, producer keeps the FIFO full with pixel value = sx[5:0] per line -> each active output equals its sx[5:0]; pix_ready toggles with backpressure; underflow stays 0.
- Stream mode, producer stops after 100 pixels of line 0 -> pixels sx>=100 are black; underflow=1 until underflow_clr; set and clear pulsed in the same cycle -> underflow stays 1.
- Mode=01, COLOR_BITS=2 -> at sx=0 rgb=00/00/00, at sx=80 b=11, at sx=639 rgb=11/11/11; blanking pixels are 0.
- Mid-line (sx=300, sy=200), FIFO holding 10 pixels, assert resync with pix_valid high for 1 cycle -> next output sx=0, sy=0, frame_start=1; FIFO empty; the push in that cycle is dropped.
